// File: rtl/mux_arb_stream_pkg.sv
// Shared definitions for the round-robin stream mux: default sizes,
// the packet-lock state encoding and the channel-index width helper.
package mux_pkg;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_NUM_INPUTS = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lockState_e;

  // Width of an index that can address n channels (never below one bit).
  function automatic int idxWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_arb_stream_if.sv
// Stream bundle between N producers, the arbitrating mux and one consumer.
// master: the environment (producers + consumer); slave: the mux itself.
interface mux_arb_stream_if
  import mux_pkg::*;
#(
  parameter int NUM_INPUTS = DEFAULT_NUM_INPUTS,
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int SEL_WIDTH  = idxWidth(NUM_INPUTS)
);

  logic [NUM_INPUTS-1:0]       in_valid;
  logic [NUM_INPUTS-1:0]       in_ready;
  logic [NUM_INPUTS*WIDTH-1:0] in_data;
  logic [NUM_INPUTS-1:0]       in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic [WIDTH-1:0]            out_data;
  logic                        out_last;
  logic [SEL_WIDTH-1:0]        out_sel;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sel
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sel
  );

endinterface

// File: rtl/mux_arb_stream_rr_arbiter.sv
// Combinational round-robin arbiter: scans requests starting at ptr_i and
// wrapping modulo NUM_INPUTS; returns a one-hot grant and its index.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_INPUTS = DEFAULT_NUM_INPUTS,
  parameter int SEL_WIDTH  = idxWidth(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req_i,
  input  logic [SEL_WIDTH-1:0]  ptr_i,
  output logic [NUM_INPUTS-1:0] grant_o,
  output logic [SEL_WIDTH-1:0]  grantIdx_o,
  output logic                  grantValid_o
);

  logic [SEL_WIDTH-1:0] scanIdx;

  // First requester at or after the pointer wins; no request, no grant.
  always_comb begin
    grant_o      = '0;
    grantIdx_o   = '0;
    grantValid_o = 1'b0;
    scanIdx      = '0;
    for (int off = 0; off < NUM_INPUTS; off++) begin
      scanIdx = SEL_WIDTH'((int'(ptr_i) + off) % NUM_INPUTS);
      if (!grantValid_o && req_i[scanIdx]) begin
        grantValid_o     = 1'b1;
        grantIdx_o       = scanIdx;
        grant_o[scanIdx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb_stream.sv
// Round-robin N-to-1 stream mux with a one-entry registered output stage.
// Optional packet lock (keep a channel granted until in_last) is enabled
// by defining MUX_ARB_LOCK_EN; without it every beat is arbitrated alone.
module mux_arb_stream
  import mux_pkg::*;
#(
  parameter int NUM_INPUTS = DEFAULT_NUM_INPUTS,
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int SEL_WIDTH  = idxWidth(NUM_INPUTS)
) (
  input  logic             clk,
  input  logic             rst,
  mux_arb_stream_if.slave  bus
);

  logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;
  logic                  outValid_q, outValid_d;
  logic [WIDTH-1:0]      outData_q, outData_d;
  logic                  outLast_q, outLast_d;
  logic [SEL_WIDTH-1:0]  outSel_q, outSel_d;

  logic                  load;
  logic                  xfer;
  logic [NUM_INPUTS-1:0] req;
  logic [NUM_INPUTS-1:0] grant;
  logic [SEL_WIDTH-1:0]  grantIdx;
  logic                  grantValid;
  logic [WIDTH-1:0]      grantData;
  logic                  grantLast;
  logic [SEL_WIDTH-1:0]  nextPtr;

  assign load = ~outValid_q | bus.out_ready;

`ifdef MUX_ARB_LOCK_EN
  lockState_e           state_q, state_d;
  logic [SEL_WIDTH-1:0] lockCh_q, lockCh_d;

  // While locked only the owning channel may request.
  always_comb begin
    req = bus.in_valid;
    if (state_q == LOCKED) begin
      req = bus.in_valid & (NUM_INPUTS'(1) << lockCh_q);
    end
  end
`else
  assign req = bus.in_valid;
`endif

  rr_arbiter #(
    .NUM_INPUTS (NUM_INPUTS),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_arb (
    .req_i        (req),
    .ptr_i        (ptr_q),
    .grant_o      (grant),
    .grantIdx_o   (grantIdx),
    .grantValid_o (grantValid)
  );

  assign grantData    = bus.in_data[grantIdx*WIDTH +: WIDTH];
  assign grantLast    = bus.in_last[grantIdx];
  assign nextPtr      = (grantIdx == SEL_WIDTH'(NUM_INPUTS - 1)) ? '0 : grantIdx + 1'b1;
  assign xfer         = grantValid & load & ~rst;
  assign bus.in_ready = (rst | ~load) ? '0 : grant;

  // Output stage: capture on transfer, empty when drained, hold when stalled.
  always_comb begin
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outLast_d  = outLast_q;
    outSel_d   = outSel_q;
    if (xfer) begin
      outValid_d = 1'b1;
      outData_d  = grantData;
      outLast_d  = grantLast;
      outSel_d   = grantIdx;
    end else if (bus.out_ready) begin
      outValid_d = 1'b0;
    end
  end

  // Pointer advance (and lock FSM): move past the winner after each transfer.
  always_comb begin
    ptr_d = ptr_q;
`ifdef MUX_ARB_LOCK_EN
    state_d  = state_q;
    lockCh_d = lockCh_q;
    if (xfer) begin
      if (state_q == IDLE) begin
        ptr_d = nextPtr;
        if (!grantLast) begin
          state_d  = LOCKED;
          lockCh_d = grantIdx;
        end
      end else if (grantLast) begin
        state_d = IDLE;
        ptr_d   = nextPtr;
      end
    end
`else
    if (xfer) begin
      ptr_d = nextPtr;
    end
`endif
  end

  // State registers with synchronous reset; a held beat is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outLast_q  <= 1'b0;
      outSel_q   <= '0;
`ifdef MUX_ARB_LOCK_EN
      state_q    <= IDLE;
      lockCh_q   <= '0;
`endif
    end else begin
      ptr_q      <= ptr_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outLast_q  <= outLast_d;
      outSel_q   <= outSel_d;
`ifdef MUX_ARB_LOCK_EN
      state_q    <= state_d;
      lockCh_q   <= lockCh_d;
`endif
    end
  end

  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;
  assign bus.out_last  = outLast_q;
  assign bus.out_sel   = outSel_q;

endmodule

// File: tb/tb_mux_arb_stream.sv
// Directed bench for mux_arb_stream (N=4, WIDTH=8): a vector table covering
// reset, round-robin, backpressure and wrap, then hand-written packet and
// reset-mid-packet sequences whose expectations depend on MUX_ARB_LOCK_EN.
module tb_mux_arb_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mux_arb_stream_if #(.NUM_INPUTS(4), .WIDTH(8)) bus ();

  mux_arb_stream #(.NUM_INPUTS(4), .WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        outReady;
    logic [3:0]  expInReady;
    logic        expValid;
    logic        chk;
    logic [7:0]  expData;
    logic        expLast;
    logic [1:0]  expSel;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] DA  = 32'hA3A2A1A0;
  localparam logic [31:0] D55 = 32'hA355A1A0;

  task automatic addVec(input logic r, input logic [3:0] v, input logic [31:0] d,
                        input logic [3:0] l, input logic ordy, input logic [3:0] eir,
                        input logic ev, input logic c, input logic [7:0] ed,
                        input logic el, input logic [1:0] es);
    vec_t t;
    t = '{r, v, d, l, ordy, eir, ev, c, ed, el, es};
    vecs.push_back(t);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, let comb logic settle.
  task automatic applyStimulus(input logic r, input logic [3:0] v, input logic [31:0] d,
                               input logic [3:0] l, input logic ordy);
    @(negedge clk);
    rst           = r;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = ordy;
    #1;
  endtask

  logic [1:0] expSel[5];
  logic [7:0] expD[5];
  int         expN;
  int         obs;
  int         beats1;

  initial begin
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.in_last   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);

    // rst, valid, data, last, ordy | inReady, oValid, chk, oData, oLast, oSel
    for (int i = 0; i < 3; i++) addVec(1, 4'hF, DA, 4'hF, 1, 4'b0000, 0, 1, 8'h00, 0, 0);
    addVec(0, 4'hF, DA, 4'hF, 1, 4'b0001, 0, 1, 8'h00, 0, 0);
    addVec(0, 4'hF, DA, 4'hF, 1, 4'b0010, 1, 1, 8'hA0, 1, 0);
    addVec(0, 4'hF, DA, 4'hF, 1, 4'b0100, 1, 1, 8'hA1, 1, 1);
    addVec(0, 4'hF, DA, 4'hF, 1, 4'b1000, 1, 1, 8'hA2, 1, 2);
    addVec(0, 4'hF, DA, 4'hF, 1, 4'b0001, 1, 1, 8'hA3, 1, 3);
    addVec(0, 4'hF, DA, 4'hF, 1, 4'b0010, 1, 1, 8'hA0, 1, 0);
    addVec(0, 4'h0, DA, 4'hF, 1, 4'b0000, 1, 1, 8'hA1, 1, 1);
    addVec(0, 4'h0, DA, 4'hF, 1, 4'b0000, 0, 0, 8'h00, 0, 0);
    addVec(0, 4'b0100, D55, 4'hF, 1, 4'b0100, 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) addVec(0, 4'hF, DA, 4'hF, 0, 4'b0000, 1, 1, 8'h55, 1, 2);
    addVec(0, 4'hF, DA, 4'hF, 1, 4'b1000, 1, 1, 8'h55, 1, 2);
    addVec(0, 4'h0, DA, 4'hF, 1, 4'b0000, 1, 1, 8'hA3, 1, 3);
    addVec(0, 4'b1000, DA, 4'hF, 1, 4'b1000, 0, 0, 8'h00, 0, 0);
    addVec(0, 4'b0001, DA, 4'b1110, 1, 4'b0001, 1, 1, 8'hA3, 1, 3);
    addVec(0, 4'h0, DA, 4'hF, 1, 4'b0000, 1, 1, 8'hA0, 0, 0);
    addVec(0, 4'h0, DA, 4'hF, 1, 4'b0000, 0, 0, 8'h00, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].outReady);
      checkOutput($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].expInReady));
      checkOutput($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].expValid));
      if (vecs[i].chk) begin
        checkOutput($sformatf("v%0d out_data", i), 32'(bus.out_data), 32'(vecs[i].expData));
        checkOutput($sformatf("v%0d out_last", i), 32'(bus.out_last), 32'(vecs[i].expLast));
        checkOutput($sformatf("v%0d out_sel", i), 32'(bus.out_sel), 32'(vecs[i].expSel));
      end
    end

    // Packet of three beats on channel 1 while channel 2 stays valid.
`ifdef MUX_ARB_LOCK_EN
    expN = 4;
    expSel[0] = 2'd1; expSel[1] = 2'd1; expSel[2] = 2'd1; expSel[3] = 2'd2; expSel[4] = 2'd0;
    expD[0] = 8'h11; expD[1] = 8'h12; expD[2] = 8'h13; expD[3] = 8'h22; expD[4] = 8'h00;
`else
    expN = 5;
    expSel[0] = 2'd1; expSel[1] = 2'd2; expSel[2] = 2'd1; expSel[3] = 2'd2; expSel[4] = 2'd1;
    expD[0] = 8'h11; expD[1] = 8'h22; expD[2] = 8'h12; expD[3] = 8'h22; expD[4] = 8'h13;
`endif
    applyStimulus(1, 4'h0, 32'h0, 4'h0, 1);
    obs    = 0;
    beats1 = 0;
    for (int cyc = 0; cyc < 20 && obs < expN; cyc++) begin
      applyStimulus(0, {1'b0, 1'b1, (beats1 < 3), 1'b0},
                    {8'h00, 8'h22, 8'(8'h11 + beats1), 8'h00},
                    {1'b0, 1'b1, (beats1 == 2), 1'b0}, 1);
      if (bus.out_valid) begin
        checkOutput($sformatf("pkt beat%0d out_sel", obs), 32'(bus.out_sel), 32'(expSel[obs]));
        checkOutput($sformatf("pkt beat%0d out_data", obs), 32'(bus.out_data), 32'(expD[obs]));
        obs++;
      end
      if (bus.in_ready[1]) beats1++;
    end
    if (obs < expN) begin
      checks++;
      errors++;
      $display("[TB] FAIL pkt timeout: got %0d beats expected %0d", obs, expN);
    end

    // Reset in the middle of a channel-1 packet, then channel 0 must win.
    applyStimulus(1, 4'h0, 32'h0, 4'h0, 1);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 4'b0010, {16'h0, 8'(8'h31 + k), 8'h40}, 4'h0, 1);
      checkOutput($sformatf("midpkt beat%0d in_ready", k), 32'(bus.in_ready), 32'b0010);
    end
    applyStimulus(1, 4'b0011, {16'h0, 8'h33, 8'h40}, 4'h0, 1);
    checkOutput("midpkt rst in_ready", 32'(bus.in_ready), 32'b0000);
    applyStimulus(0, 4'b0011, {16'h0, 8'h33, 8'h40}, 4'h0, 1);
    checkOutput("midpkt post-rst out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midpkt post-rst in_ready", 32'(bus.in_ready), 32'b0001);
    applyStimulus(0, 4'b0000, 32'h0, 4'h0, 1);
    checkOutput("midpkt out_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("midpkt out_sel", 32'(bus.out_sel), 32'd0);
    checkOutput("midpkt out_data", 32'(bus.out_data), 32'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mux_arb_stream.md
Name: mux_arb_stream

Overview:
- Parametrised successor of the generic N-to-1 data mux.
- Select is no longer an external input: a round-robin arbiter picks among NUM_INPUTS valid/ready streaming channels.
- The winner's beat is registered into a single output stage with backpressure.
- Sits between multiple stream producers and one shared consumer (e.g. several cocotb-driven sources feeding one sink).

Parameters:
- NUM_INPUTS, 4, number of input channels, must be ≥2.
- WIDTH, 8, data width per channel in bits.
- SEL_WIDTH, $clog2(NUM_INPUTS), width of the channel index on out_sel.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  NUM_INPUTS  per-channel beat valid.
- in_ready  output  NUM_INPUTS  per-channel accept; at most one bit high per cycle.
- in_data  input  NUM_INPUTS*WIDTH  packed flat bus; channel i at [i*WIDTH +: WIDTH].
- in_last  input  NUM_INPUTS  per-channel end-of-packet flag; used only when MUX_ARB_LOCK_EN is defined, otherwise passed through only.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat.
- out_data  output  WIDTH  registered data of the granted channel.
- out_last  output  1  registered in_last of the granted channel.
- out_sel  output  SEL_WIDTH  index of the channel that supplied the current out_data.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_last=0, out_sel=0.
  - Round-robin pointer ptr=0; lock state cleared.
  - in_ready is all-zero while rst=1.
- Load enable: load = ~out_valid | out_ready.
- Output stage: one-entry register; full-throughput, one beat per cycle when out_ready stays high.
- Arbitration (combinational):
  - Scan channels ptr, ptr+1, … modulo NUM_INPUTS; grant = first index with in_valid=1.
  - No valid input means no grant.
- in_ready[g] = load for the granted g only; all other in_ready bits are 0.
- Transfer on channel g: in_valid[g] & in_ready[g].
  - Next cycle: out_data, out_last and out_sel capture the channel-g values; out_valid=1.
  - Latency from input accept to out_valid is 1 cycle.
- out_valid & out_ready with no new transfer: out_valid drops to 0 next cycle.
- out_valid=1 & out_ready=0: all output registers hold and in_ready is all-zero (no beat dropped or overwritten).
- Pointer update: after a transfer from g, ptr <= (g+1) mod NUM_INPUTS, wrapping from NUM_INPUTS-1 to 0. There is no update without a transfer.
- Arbitration is work-conserving and starvation-free: each continuously valid channel is served within NUM_INPUTS transfers.
- in_data of channels that are not granted is ignored; a producer may change it freely.
- Reset mid-stream: the beat held in the output register is discarded; the consumer must tolerate this.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- Defined: packet lock with a two-state FSM, IDLE and LOCKED(ch).
  - IDLE: arbitrate normally. A transfer from g with in_last=0 moves to LOCKED(g); in_last=1 stays in IDLE.
  - LOCKED(ch): only channel ch is eligible and other valids are ignored. ptr is frozen. A transfer with in_last=1 moves to IDLE and sets ptr <= ch+1 mod N.
  - rst in any state returns to IDLE.
- Undefined: no FSM; every beat is arbitrated independently. in_last only feeds out_last.

Decomposition:
- Shared package mux_pkg holds:
  - the clog2-based index-width helper;
  - localparam state encodings IDLE=1'b0, LOCKED=1'b1;
  - the default WIDTH and NUM_INPUTS constants.
- One natural sub-module: rr_arbiter (NUM_INPUTS). It takes req and ptr and returns a one-hot grant plus an encoded index. It is reusable by later multi-channel blocks.

Test Plan:
- Reset: hold rst 3 cycles with all in_valid=1. Required: out_valid=0, out_data=0, out_sel=0 and in_ready=0 throughout; after release, the first grant goes to channel 0.
- Round-robin: N=4, all four channels constantly valid with data 0xA0+i, out_ready=1. Required: out_sel sequence 0,1,2,3,0,1…; out_data 0xA0,0xA1,0xA2,0xA3,…; one beat per cycle after 1-cycle latency.
- Backpressure: channel 2 sends 0x55, then out_ready=0 for 5 cycles. Required: out_valid=1, out_data=0x55 and out_sel=2 are stable; in_ready=0000; no loss; the next beat follows the cycle after out_ready=1.
- Sparse request and wrap: only channel 3 is valid, then only channel 0. Required: grant 3, then ptr wraps to 0 and channel 0 is granted on the next cycle.
- Lock (MUX_ARB_LOCK_EN): channel 1 sends a 3-beat packet (last on beat 3) while channel 2 stays valid. Required: out_sel = 1,1,1, then 2. Without the macro the same stimulus gives out_sel = 1,2,1,2,1.
- Reset mid-packet (MUX_ARB_LOCK_EN): assert rst after beat 2 of the channel-1 packet. Required: FSM returns to IDLE; on release, channel 0 (ptr=0) wins if it is valid.
